// File: rtl/wide_sub_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sub_seq_pkg
// Shared types and helpers for the chunked wide subtractor (wide_sub_sequencer).
//   sub_state_t : controller state encoding (IDLE / RUN / DONE).
//   nch()       : number of CHUNK-wide slices in a W-bit operand.
//   idx_w()     : width of the chunk index counter (never below 1 bit).
// -----------------------------------------------------------------------------
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic int nch(input int w, input int chunk);
        return w / chunk;
    endfunction

    // A single-chunk operation still needs a 1-bit index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_sub_sequencer_if.sv
// -----------------------------------------------------------------------------
// wide_sub_sequencer_if
// Operand / result handshake bundle for wide_sub_sequencer.
//   start_valid/start_ready : operand handshake (a_in, b_in, bin_in)
//   res_valid/res_ready     : result handshake (diff_out, bout_out, zero_out)
//   busy                    : controller is not idle
// modport slave  : the sequencer side
// modport master : the requester / consumer side
// -----------------------------------------------------------------------------
interface wide_sub_sequencer_if #(
    parameter int W = 32
);
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] diff_out;
    logic         bout_out;
    logic         zero_out;
    logic         busy;

    modport slave (
        input  start_valid, a_in, b_in, bin_in, res_ready,
        output start_ready, res_valid, diff_out, bout_out, zero_out, busy
    );

    modport master (
        output start_valid, a_in, b_in, bin_in, res_ready,
        input  start_ready, res_valid, diff_out, bout_out, zero_out, busy
    );
endinterface

// File: rtl/wide_sub_sequencer_fsub.sv
// -----------------------------------------------------------------------------
// full_sub
// Combinational N-bit full subtractor: diff_o = a_i - b_i - bin_i (mod 2^N),
// bout_o = 1 when a_i < b_i + bin_i (unsigned).
//   a_i, b_i : N-bit operands
//   bin_i    : borrow in
//   diff_o   : N-bit difference
//   bout_o   : borrow out
// -----------------------------------------------------------------------------
module full_sub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         bin_i,
    output logic [N-1:0] diff_o,
    output logic         bout_o
);
    logic [N:0] ext;

    // One extra bit catches the borrow: the true result lies in
    // [-2^N, 2^N-1], so bit N is set exactly when it went negative.
    assign ext = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, bin_i};
    assign {bout_o, diff_o} = ext;
endmodule

// File: rtl/wide_sub_sequencer.sv
// -----------------------------------------------------------------------------
// wide_sub_sequencer
// Computes a W-bit A - B - BIN with one CHUNK-bit full subtractor, one chunk
// per cycle, LSB chunk first; the inter-chunk borrow lives in a register.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : wide_sub_sequencer_if.slave
//            start_valid/start_ready, a_in, b_in, bin_in  (operands)
//            res_valid/res_ready, diff_out, bout_out, zero_out (result)
//            busy (state != IDLE)
// Latency: res_valid rises NCH edges after the accepting edge.
// -----------------------------------------------------------------------------
module wide_sub_sequencer
    import sub_seq_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_sub_sequencer_if.slave  bus
);
    localparam int NCH  = nch(W, CHUNK);
    localparam int IDXW = idx_w(NCH);

    generate
        if ((CHUNK < 1) || (W % CHUNK != 0)) begin : g_bad_params
            $error("wide_sub_sequencer: W must be a positive multiple of CHUNK");
        end
    endgenerate

    sub_state_t       state_q, state_d;
    logic [IDXW-1:0]  idx_q;
    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     diff_q;
    logic             borrow_q;

    logic [CHUNK-1:0] a_chunk, b_chunk, slice_diff;
    logic             slice_bout;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_valid)                  state_d = RUN;
            RUN:     if (idx_q == IDXW'(NCH - 1))          state_d = DONE;
            DONE:    if (bus.res_ready)                    state_d = IDLE;
            default:                                       state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Borrow and zero flags are only meaningful in DONE; gating them keeps
    // intermediate chunk borrows and stale results off the outputs.
    always_comb begin
        bus.start_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.busy        = 1'b1;
        bus.diff_out    = diff_q;
        bus.bout_out    = 1'b0;
        bus.zero_out    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                bus.bout_out  = borrow_q;
                bus.zero_out  = (diff_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------- chunk mux into the shared slice ----------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    full_sub #(.N(CHUNK)) u_slice (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .bin_i  (borrow_q),
        .diff_o (slice_diff),
        .bout_o (slice_bout)
    );

    // ---------------- operand / result datapath ----------------
    // Operands are captured only on the accepting edge, so the slice never
    // sees the live input bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q      <= bus.a_in;
                        b_q      <= bus.b_in;
                        borrow_q <= bus.bin_in;
                        idx_q    <= '0;
                        diff_q   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (idx_q == IDXW'(i)) diff_q[i*CHUNK +: CHUNK] <= slice_diff;
                    end
                    borrow_q <= slice_bout;
                    idx_q    <= idx_q + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_sub_sequencer.sv
module tb_wide_sub_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        z;
    } vec_t;

    exp_t q32[$];
    exp_t q8[$];

    wide_sub_sequencer_if #(.W(32)) s32 ();
    wide_sub_sequencer_if #(.W(8))  s8  ();

    wide_sub_sequencer #(.W(32), .CHUNK(8)) u32 (.clk(clk), .rst(rst), .bus(s32));
    wide_sub_sequencer #(.W(8),  .CHUNK(8)) u8  (.clk(clk), .rst(rst), .bus(s8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!rst && s32.res_valid && s32.res_ready) begin
            if (q32.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w32_unexpected_result: got diff 0x%08h expected none", s32.diff_out);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("w32_diff", s32.diff_out, e.diff);
                chk("w32_bout", {31'b0, s32.bout_out}, {31'b0, e.bout});
                chk("w32_zero", {31'b0, s32.zero_out}, {31'b0, e.zero});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s8.res_valid && s8.res_ready) begin
            if (q8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w8_unexpected_result: got diff 0x%02h expected none", s8.diff_out);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_diff", {24'b0, s8.diff_out}, e.diff);
                chk("w8_bout", {31'b0, s8.bout_out}, {31'b0, e.bout});
                chk("w8_zero", {31'b0, s8.zero_out}, {31'b0, e.zero});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [31:0] ed, input logic eb, input logic ez);
        int n = 0;
        @(negedge clk);
        s32.start_valid = 1'b1; s32.a_in = a; s32.b_in = b; s32.bin_in = bi;
        while (!s32.start_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL w32_accept_timeout: start_ready stayed 0 for %0d cycles", n);
        end else begin
            q32.push_back('{diff: ed, bout: eb, zero: ez});
        end
        @(posedge clk); #1;
        // Scramble the bus after acceptance; the result must not change.
        s32.start_valid = 1'b0; s32.a_in = ~a; s32.b_in = a ^ b; s32.bin_in = ~bi;
    endtask

    task automatic wait32(input int exp_lat);
        int n = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (s32.res_valid) break;
        end
        chk("w32_latency", n, exp_lat);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic ez);
        int n = 0;
        @(negedge clk);
        s8.start_valid = 1'b1; s8.a_in = a; s8.b_in = b; s8.bin_in = bi;
        while (!s8.start_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL w8_accept_timeout: start_ready stayed 0 for %0d cycles", n);
        end else begin
            q8.push_back('{diff: {24'b0, ed}, bout: eb, zero: ez});
        end
        @(posedge clk); #1;
        s8.start_valid = 1'b0; s8.a_in = ~a; s8.b_in = ~b; s8.bin_in = ~bi;
    endtask

    task automatic wait8(input int exp_lat);
        int n = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (s8.res_valid) break;
        end
        chk("w8_latency", n, exp_lat);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{a: 32'd10,         b: 32'd4,          bi: 1'b1, d: 32'd5,          bo: 1'b0, z: 1'b0};
        vecs[1] = '{a: 32'd122,        b: 32'd129,        bi: 1'b0, d: 32'hFFFF_FFF9,  bo: 1'b1, z: 1'b0};
        vecs[2] = '{a: 32'd1,          b: 32'd1,          bi: 1'b1, d: 32'hFFFF_FFFF,  bo: 1'b1, z: 1'b0};
        vecs[3] = '{a: 32'd1,          b: 32'd1,          bi: 1'b0, d: 32'd0,          bo: 1'b0, z: 1'b1};
        vecs[4] = '{a: 32'h0100_0000,  b: 32'd1,          bi: 1'b0, d: 32'h00FF_FFFF,  bo: 1'b0, z: 1'b0};
        vecs[5] = '{a: 32'd0,          b: 32'hFFFF_FFFF,  bi: 1'b1, d: 32'd0,          bo: 1'b1, z: 1'b1};
        vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'd0,          bi: 1'b0, d: 32'hFFFF_FFFF,  bo: 1'b0, z: 1'b0};
        vecs[7] = '{a: 32'h1234_5678,  b: 32'h0234_5679,  bi: 1'b0, d: 32'h0FFF_FFFF,  bo: 1'b0, z: 1'b0};

        s32.start_valid = 1'b0; s32.a_in = '0; s32.b_in = '0; s32.bin_in = 1'b0; s32.res_ready = 1'b1;
        s8.start_valid  = 1'b0; s8.a_in  = '0; s8.b_in  = '0; s8.bin_in  = 1'b0; s8.res_ready  = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", {31'b0, s32.start_ready}, 32'd1);
        chk("rst_res_valid",   {31'b0, s32.res_valid},   32'd0);
        chk("rst_diff",        s32.diff_out,             32'd0);
        chk("rst_bout",        {31'b0, s32.bout_out},    32'd0);
        chk("rst_zero",        {31'b0, s32.zero_out},    32'd0);
        chk("rst_busy",        {31'b0, s32.busy},        32'd0);
        chk("rst_w8_ready",    {31'b0, s8.start_ready},  32'd1);
        rst = 1'b0;

        // Directed vectors, 4-cycle latency each
        foreach (vecs[i]) begin
            send32(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].z);
            wait32(4);
        end

        // Backpressure: result frozen, new start refused
        @(posedge clk); #1;
        s32.res_ready = 1'b0;
        send32(32'h0000_1000, 32'd1, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0);
        wait32(4);
        s32.start_valid = 1'b1; s32.a_in = 32'd99; s32.b_in = 32'd3; s32.bin_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("bp_diff_hold",   s32.diff_out,             32'h0000_0FFF);
            chk("bp_start_ready", {31'b0, s32.start_ready}, 32'd0);
            chk("bp_res_valid",   {31'b0, s32.res_valid},   32'd1);
        end
        s32.start_valid = 1'b0;
        s32.res_ready   = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_busy", {31'b0, s32.busy}, 32'd0);
        send32(32'd99, 32'd3, 1'b0, 32'd96, 1'b0, 1'b0);
        wait32(4);

        // Reset two cycles after accept abandons the operation
        send32(32'd1000, 32'd1, 1'b0, 32'd999, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q32.delete();
        chk("midrst_res_valid",   {31'b0, s32.res_valid},   32'd0);
        chk("midrst_busy",        {31'b0, s32.busy},        32'd0);
        chk("midrst_start_ready", {31'b0, s32.start_ready}, 32'd1);
        chk("midrst_diff",        s32.diff_out,             32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_result", {31'b0, s32.res_valid}, 32'd0);
        send32(32'd50, 32'd17, 1'b1, 32'd32, 1'b0, 1'b0);
        wait32(4);

        // Single-chunk instance
        send8(8'd189, 8'd20, 1'b0, 8'd169, 1'b0, 1'b0);
        wait8(1);
        send8(8'd20, 8'd189, 1'b0, 8'd87, 1'b1, 1'b0);
        wait8(1);
        send8(8'd5, 8'd4, 1'b1, 8'd0, 1'b0, 1'b1);
        wait8(1);

        repeat (3) @(posedge clk);
        #1;
        chk("w32_sb_drained", q32.size(), 32'd0);
        chk("w8_sb_drained",  q8.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
